// File: rtl/sdr_cmd_arb_pkg.sv
// Shared definitions for the SDRAM command arbiter: bus widths, NOP encoding,
// FSM state and pin-source encodings.
package sdr_cmd_arb_pkg;

    localparam int unsigned BA_WIDTH  = 2;
    localparam int unsigned ROW_WIDTH = 12;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] CmdNop = 3'b111;

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StIdle    = 3'd1,
        StRw      = 3'd2,
        StRefPend = 3'd3,
        StRef     = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        SrcNop  = 2'd0,
        SrcInit = 2'd1,
        SrcRw   = 2'd2
    } cmd_src_e;

endpackage

// File: rtl/sdr_cmd_arb_if.sv
// Handshake and command-bus bundle between the arbiter, the init/refresh
// generator, the read/write engine and the SDRAM pins.
interface sdr_cmd_arb_if #(
    parameter int unsigned BA_WIDTH  = sdr_cmd_arb_pkg::BA_WIDTH,
    parameter int unsigned ROW_WIDTH = sdr_cmd_arb_pkg::ROW_WIDTH
) ();

    logic                 Sdr_init_done;
    logic                 Sdr_ref_req;
    logic                 Sdr_ref_ack;
    logic                 Sdr_rw_vld;
    logic                 Sdr_init_ref_vld;
    logic                 Sdr_init_ref_ras;
    logic                 Sdr_init_ref_cas;
    logic                 Sdr_init_ref_we;
    logic [BA_WIDTH-1:0]  Sdr_init_ref_ba;
    logic [ROW_WIDTH:0]   Sdr_init_ref_addr;
    logic                 Rw_req;
    logic                 Rw_gnt;
    logic                 Rw_done;
    logic                 Rw_ras;
    logic                 Rw_cas;
    logic                 Rw_we;
    logic [BA_WIDTH-1:0]  Rw_ba;
    logic [ROW_WIDTH:0]   Rw_addr;
    logic                 Sdr_cs_n;
    logic                 Sdr_ras_n;
    logic                 Sdr_cas_n;
    logic                 Sdr_we_n;
    logic [BA_WIDTH-1:0]  Sdr_ba;
    logic [ROW_WIDTH:0]   Sdr_addr;
    logic                 Ref_timeout_err;

    modport master (
        output Sdr_init_done, Sdr_ref_req, Sdr_init_ref_vld, Sdr_init_ref_ras,
               Sdr_init_ref_cas, Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
               Rw_req, Rw_done, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        input  Sdr_ref_ack, Sdr_rw_vld, Rw_gnt, Sdr_cs_n, Sdr_ras_n, Sdr_cas_n,
               Sdr_we_n, Sdr_ba, Sdr_addr, Ref_timeout_err
    );

    modport slave (
        input  Sdr_init_done, Sdr_ref_req, Sdr_init_ref_vld, Sdr_init_ref_ras,
               Sdr_init_ref_cas, Sdr_init_ref_we, Sdr_init_ref_ba, Sdr_init_ref_addr,
               Rw_req, Rw_done, Rw_ras, Rw_cas, Rw_we, Rw_ba, Rw_addr,
        output Sdr_ref_ack, Sdr_rw_vld, Rw_gnt, Sdr_cs_n, Sdr_ras_n, Sdr_cas_n,
               Sdr_we_n, Sdr_ba, Sdr_addr, Ref_timeout_err
    );

endinterface

// File: rtl/sdr_cmd_reg.sv
// Registered SDRAM pin mux: picks the init/refresh or read/write source and
// forces NOP when the chosen source is not valid.
module sdr_cmd_reg
    import sdr_cmd_arb_pkg::*;
#(
    parameter int unsigned BA_WIDTH  = sdr_cmd_arb_pkg::BA_WIDTH,
    parameter int unsigned ROW_WIDTH = sdr_cmd_arb_pkg::ROW_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  cmd_src_e            src_i,
    input  logic                init_vld_i,
    input  logic [2:0]          init_cmd_i,
    input  logic [BA_WIDTH-1:0] init_ba_i,
    input  logic [ROW_WIDTH:0]  init_addr_i,
    input  logic                rw_vld_i,
    input  logic [2:0]          rw_cmd_i,
    input  logic [BA_WIDTH-1:0] rw_ba_i,
    input  logic [ROW_WIDTH:0]  rw_addr_i,
    output logic [2:0]          cmd_o,
    output logic [BA_WIDTH-1:0] ba_o,
    output logic [ROW_WIDTH:0]  addr_o
);

    logic [2:0]          cmd_d, cmd_q;
    logic [BA_WIDTH-1:0] ba_d, ba_q;
    logic [ROW_WIDTH:0]  addr_d, addr_q;

    always_comb begin
        cmd_d  = CmdNop;
        ba_d   = '0;
        addr_d = '0;
        unique case (src_i)
            SrcInit: begin
                if (init_vld_i) begin
                    cmd_d  = init_cmd_i;
                    ba_d   = init_ba_i;
                    addr_d = init_addr_i;
                end
            end
            SrcRw: begin
                if (rw_vld_i) begin
                    cmd_d  = rw_cmd_i;
                    ba_d   = rw_ba_i;
                    addr_d = rw_addr_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_q  <= CmdNop;
            ba_q   <= '0;
            addr_q <= '0;
        end else begin
            cmd_q  <= cmd_d;
            ba_q   <= ba_d;
            addr_q <= addr_d;
        end
    end

    assign cmd_o  = cmd_q;
    assign ba_o   = ba_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/sdr_cmd_arb.sv
// SDRAM command-bus arbiter between the init/refresh sequencer and the read/write
// engine. Optional statistics outputs are enabled by defining SDR_ARB_STAT_EN.
module sdr_cmd_arb
    import sdr_cmd_arb_pkg::*;
#(
    parameter int unsigned BA_WIDTH    = sdr_cmd_arb_pkg::BA_WIDTH,
    parameter int unsigned ROW_WIDTH   = sdr_cmd_arb_pkg::ROW_WIDTH,
    parameter int unsigned REF_TIMEOUT = 32
) (
    input  logic         Sdr_clk,
    input  logic         Rst,
    sdr_cmd_arb_if.slave bus
`ifdef SDR_ARB_STAT_EN
    ,
    output logic [15:0]  Stat_ref_cnt,
    output logic [7:0]   Stat_ref_lat_max
`endif
);

    localparam logic [5:0] RefLast = 6'(REF_TIMEOUT - 1);

    arb_state_e state_d, state_q;
    logic       ack_d, ack_q;
    logic       rw_vld_d, rw_vld_q;
    logic       gnt_d, gnt_q;
    logic       pend_d, pend_q;
    logic       seen_d, seen_q;
    logic       err_d, err_q;
    logic [5:0] tmo_d, tmo_q;
    cmd_src_e   src;
    logic [2:0] pin_cmd;

    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        rw_vld_d = rw_vld_q;
        gnt_d    = gnt_q;
        pend_d   = pend_q;
        seen_d   = seen_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        if (!bus.Sdr_init_done) begin
            // Re-init request wins over everything, including an open RW burst.
            state_d  = StInit;
            gnt_d    = 1'b0;
            rw_vld_d = 1'b0;
            pend_d   = 1'b0;
        end else begin
            unique case (state_q)
                StInit: state_d = StIdle;
                StIdle: begin
                    if (bus.Sdr_ref_req) begin
                        ack_d   = 1'b1;
                        seen_d  = 1'b0;
                        tmo_d   = '0;
                        state_d = StRef;
                    end else if (bus.Rw_req) begin
                        gnt_d    = 1'b1;
                        rw_vld_d = 1'b1;
                        state_d  = StRw;
                    end
                end
                StRw: begin
                    pend_d = pend_q | bus.Sdr_ref_req;
                    if (bus.Rw_done) begin
                        gnt_d    = 1'b0;
                        rw_vld_d = 1'b0;
                        state_d  = pend_d ? StRefPend : StIdle;
                    end
                end
                StRefPend: begin
                    ack_d   = 1'b1;
                    pend_d  = 1'b0;
                    seen_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = StRef;
                end
                StRef: begin
                    tmo_d = tmo_q + 6'd1;
                    if (bus.Sdr_init_ref_vld) begin
                        seen_d = 1'b1;
                    end else if (seen_q) begin
                        state_d = StIdle;
                    end else if (tmo_q == RefLast) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            state_q  <= StInit;
            ack_q    <= 1'b0;
            rw_vld_q <= 1'b0;
            gnt_q    <= 1'b0;
            pend_q   <= 1'b0;
            seen_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rw_vld_q <= rw_vld_d;
            gnt_q    <= gnt_d;
            pend_q   <= pend_d;
            seen_q   <= seen_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        unique case (state_q)
            StInit, StRef: src = SrcInit;
            StRw:          src = SrcRw;
            default:       src = SrcNop;
        endcase
    end

    sdr_cmd_reg #(
        .BA_WIDTH  (BA_WIDTH),
        .ROW_WIDTH (ROW_WIDTH)
    ) u_cmd_reg (
        .clk_i       (Sdr_clk),
        .rst_i       (Rst),
        .src_i       (src),
        .init_vld_i  (bus.Sdr_init_ref_vld),
        .init_cmd_i  ({bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we}),
        .init_ba_i   (bus.Sdr_init_ref_ba),
        .init_addr_i (bus.Sdr_init_ref_addr),
        .rw_vld_i    (gnt_q),
        .rw_cmd_i    ({bus.Rw_ras, bus.Rw_cas, bus.Rw_we}),
        .rw_ba_i     (bus.Rw_ba),
        .rw_addr_i   (bus.Rw_addr),
        .cmd_o       (pin_cmd),
        .ba_o        (bus.Sdr_ba),
        .addr_o      (bus.Sdr_addr)
    );

    assign bus.Sdr_cs_n        = 1'b0;
    assign bus.Sdr_ras_n       = pin_cmd[2];
    assign bus.Sdr_cas_n       = pin_cmd[1];
    assign bus.Sdr_we_n        = pin_cmd[0];
    assign bus.Sdr_ref_ack     = ack_q;
    assign bus.Sdr_rw_vld      = rw_vld_q;
    assign bus.Rw_gnt          = gnt_q;
    assign bus.Ref_timeout_err = err_q;

`ifdef SDR_ARB_STAT_EN
    logic [15:0] stat_cnt_d, stat_cnt_q;
    logic [7:0]  lat_d, lat_q, lat_max_d, lat_max_q;
    logic        capture;

    // A request is captured when it is first seen by IDLE or while RW has none latched.
    assign capture = bus.Sdr_init_done & bus.Sdr_ref_req &
                     ((state_q == StIdle) | ((state_q == StRw) & ~pend_q));

    always_comb begin
        lat_d      = capture ? 8'd1 : ((lat_q == 8'hFF) ? lat_q : lat_q + 8'd1);
        stat_cnt_d = stat_cnt_q;
        lat_max_d  = lat_max_q;
        if (ack_d) begin
            if (stat_cnt_q != 16'hFFFF) stat_cnt_d = stat_cnt_q + 16'd1;
            if (lat_d > lat_max_q)      lat_max_d  = lat_d;
        end
    end

    always_ff @(posedge Sdr_clk) begin
        if (Rst) begin
            stat_cnt_q <= '0;
            lat_q      <= '0;
            lat_max_q  <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            lat_q      <= lat_d;
            lat_max_q  <= lat_max_d;
        end
    end

    assign Stat_ref_cnt     = stat_cnt_q;
    assign Stat_ref_lat_max = lat_max_q;
`endif

endmodule

// File: tb/tb_sdr_cmd_arb.sv
// Directed bench for sdr_cmd_arb: a vector table for pass-through/mux behaviour
// plus hand sequences for refresh, pending refresh, timeout and re-init.
module tb_sdr_cmd_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdr_cmd_arb_if #(.BA_WIDTH(2), .ROW_WIDTH(12)) bus ();

`ifdef SDR_ARB_STAT_EN
    logic [15:0] stat_cnt;
    logic [7:0]  stat_lat;
`endif

    sdr_cmd_arb #(
        .BA_WIDTH    (2),
        .ROW_WIDTH   (12),
        .REF_TIMEOUT (32)
    ) dut (
        .Sdr_clk          (clk),
        .Rst              (rst),
        .bus              (bus)
`ifdef SDR_ARB_STAT_EN
        ,
        .Stat_ref_cnt     (stat_cnt),
        .Stat_ref_lat_max (stat_lat)
`endif
    );

    typedef struct {
        logic        init_done;
        logic        ref_req;
        logic        iv;
        logic [2:0]  icmd;
        logic [1:0]  iba;
        logic [12:0] iaddr;
        logic        rw_req;
        logic        rw_done;
        logic [2:0]  rcmd;
        logic [1:0]  rba;
        logic [12:0] raddr;
        logic [2:0]  xcmd;
        logic [1:0]  xba;
        logic [12:0] xaddr;
        logic        xgnt;
    } vec_t;

    vec_t vecs[7];
    int total = 0;
    int bad = 0;
    int ack_count = 0;
    int overlap = 0;
    int gnt_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pins(input string name, input logic [2:0] cmd, input logic [1:0] ba,
                              input logic [12:0] addr);
        check({name, "_cmd"}, {29'd0, bus.Sdr_ras_n, bus.Sdr_cas_n, bus.Sdr_we_n}, {29'd0, cmd});
        check({name, "_ba"}, {30'd0, bus.Sdr_ba}, {30'd0, ba});
        check({name, "_addr"}, {19'd0, bus.Sdr_addr}, {19'd0, addr});
        check({name, "_cs"}, {31'd0, bus.Sdr_cs_n}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.Sdr_ref_ack) ack_count++;
        if (bus.Sdr_ref_ack && bus.Sdr_rw_vld) overlap++;
    endtask

    task automatic set_init(input logic iv, input logic [2:0] cmd, input logic [1:0] ba,
                            input logic [12:0] addr);
        bus.Sdr_init_ref_vld = iv;
        {bus.Sdr_init_ref_ras, bus.Sdr_init_ref_cas, bus.Sdr_init_ref_we} = cmd;
        bus.Sdr_init_ref_ba   = ba;
        bus.Sdr_init_ref_addr = addr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          id   rr   iv   icmd    iba   iaddr    rq   rd   rcmd    rba   raddr    xcmd    xba   xaddr    g
        vecs[0] = '{1'b0,1'b0,1'b1,3'b010,2'd1,13'h400,1'b1,1'b0,3'b000,2'd0,13'h000,3'b010,2'd1,13'h400,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b0,3'b000,2'd2,13'h0ff,1'b1,1'b0,3'b000,2'd0,13'h000,3'b111,2'd0,13'h000,1'b0};
        vecs[2] = '{1'b1,1'b0,1'b1,3'b001,2'd2,13'h0aa,1'b0,1'b0,3'b000,2'd0,13'h000,3'b001,2'd2,13'h0aa,1'b0};
        vecs[3] = '{1'b1,1'b0,1'b1,3'b000,2'd0,13'h000,1'b1,1'b0,3'b011,2'd3,13'h123,3'b111,2'd0,13'h000,1'b1};
        vecs[4] = '{1'b1,1'b0,1'b1,3'b000,2'd1,13'h001,1'b1,1'b0,3'b011,2'd3,13'h123,3'b011,2'd3,13'h123,1'b1};
        vecs[5] = '{1'b1,1'b0,1'b1,3'b000,2'd1,13'h001,1'b1,1'b1,3'b101,2'd2,13'h010,3'b101,2'd2,13'h010,1'b0};
        vecs[6] = '{1'b1,1'b0,1'b1,3'b000,2'd1,13'h001,1'b0,1'b0,3'b000,2'd1,13'h001,3'b111,2'd0,13'h000,1'b0};

        rst = 1'b1;
        bus.Sdr_init_done = 1'b0;
        bus.Sdr_ref_req   = 1'b0;
        set_init(1'b0, 3'b000, 2'd0, 13'h0);
        bus.Rw_req  = 1'b0;
        bus.Rw_done = 1'b0;
        {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = 3'b000;
        bus.Rw_ba   = 2'd0;
        bus.Rw_addr = 13'h0;
        step();
        step();
        check_pins("reset", 3'b111, 2'd0, 13'h0);
        check("reset_ack", {31'd0, bus.Sdr_ref_ack}, 32'd0);
        check("reset_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd0);
        check("reset_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
        check("reset_err", {31'd0, bus.Ref_timeout_err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bus.Sdr_init_done = vecs[i].init_done;
            bus.Sdr_ref_req   = vecs[i].ref_req;
            set_init(vecs[i].iv, vecs[i].icmd, vecs[i].iba, vecs[i].iaddr);
            bus.Rw_req  = vecs[i].rw_req;
            bus.Rw_done = vecs[i].rw_done;
            {bus.Rw_ras, bus.Rw_cas, bus.Rw_we} = vecs[i].rcmd;
            bus.Rw_ba   = vecs[i].rba;
            bus.Rw_addr = vecs[i].raddr;
            step();
            check_pins($sformatf("vec%0d", i), vecs[i].xcmd, vecs[i].xba, vecs[i].xaddr);
            check($sformatf("vec%0d_gnt", i), {31'd0, bus.Rw_gnt}, {31'd0, vecs[i].xgnt});
        end

        // Refresh and RW request together: refresh wins, RW waits out the window.
        bus.Sdr_ref_req = 1'b1;
        bus.Rw_req      = 1'b1;
        step();
        check("tie_ack", {31'd0, bus.Sdr_ref_ack}, 32'd1);
        check("tie_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd0);
        check("tie_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
        bus.Sdr_ref_req = 1'b0;
        set_init(1'b1, 3'b001, 2'd0, 13'h400);
        gnt_hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) begin
                check("ref_ack_pulse", {31'd0, bus.Sdr_ref_ack}, 32'd0);
                check_pins("ref_pass", 3'b001, 2'd0, 13'h400);
            end
            if (bus.Rw_gnt) gnt_hi++;
        end
        check("ref_window_gnt", gnt_hi, 0);
        set_init(1'b0, 3'b000, 2'd0, 13'h0);
        step();
        check_pins("ref_end_nop", 3'b111, 2'd0, 13'h0);
        check("ref_end_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
        step();
        check("after_ref_gnt", {31'd0, bus.Rw_gnt}, 32'd1);
        check("after_ref_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd1);

        // Two refresh requests during RW collapse into one ack after release.
        ack_count = 0;
        for (int i = 0; i < 10; i++) begin
            bus.Sdr_ref_req = (i == 1 || i == 3);
            bus.Rw_done     = (i == 9);
            step();
        end
        check("rwdone_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
        check("rwdone_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd0);
        check("rwdone_ack", {31'd0, bus.Sdr_ref_ack}, 32'd0);
        bus.Sdr_ref_req = 1'b0;
        bus.Rw_done     = 1'b0;
        bus.Rw_req      = 1'b0;
        step();
        check("pend_ack", {31'd0, bus.Sdr_ref_ack}, 32'd1);
        check("pend_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd0);
        set_init(1'b1, 3'b001, 2'd0, 13'h0);
        step();
        set_init(1'b0, 3'b000, 2'd0, 13'h0);
        step();
        check("pend_ack_count", ack_count, 1);

        // Ack with no refresh activity: abandoned after REF_TIMEOUT cycles.
        bus.Sdr_ref_req = 1'b1;
        step();
        check("tmo_ack", {31'd0, bus.Sdr_ref_ack}, 32'd1);
        bus.Sdr_ref_req = 1'b0;
        for (int i = 0; i < 31; i++) step();
        check("tmo_early_err", {31'd0, bus.Ref_timeout_err}, 32'd0);
        step();
        check("tmo_err", {31'd0, bus.Ref_timeout_err}, 32'd1);
        bus.Rw_req = 1'b1;
        step();
        check("tmo_idle_gnt", {31'd0, bus.Rw_gnt}, 32'd1);
        check("tmo_err_sticky", {31'd0, bus.Ref_timeout_err}, 32'd1);

        // Re-init request mid-RW.
        bus.Sdr_init_done = 1'b0;
        step();
        check("reinit_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
        check("reinit_rwvld", {31'd0, bus.Sdr_rw_vld}, 32'd0);
        set_init(1'b1, 3'b010, 2'd3, 13'h055);
        step();
        check_pins("reinit_pass", 3'b010, 2'd3, 13'h055);
        check("reinit_gnt2", {31'd0, bus.Rw_gnt}, 32'd0);
        check("reinit_err_sticky", {31'd0, bus.Ref_timeout_err}, 32'd1);
        check("ack_rw_overlap", overlap, 0);
`ifdef SDR_ARB_STAT_EN
        check("stat_ref_cnt", {16'd0, stat_cnt}, 32'd3);
        check("stat_lat_max", {24'd0, stat_lat}, 32'd10);
`endif

        rst = 1'b1;
        step();
        check("rst_err", {31'd0, bus.Ref_timeout_err}, 32'd0);
        check_pins("rst_pins", 3'b111, 2'd0, 13'h0);
        check("rst_gnt", {31'd0, bus.Rw_gnt}, 32'd0);
`ifdef SDR_ARB_STAT_EN
        check("rst_stat_cnt", {16'd0, stat_cnt}, 32'd0);
`endif
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
